piezo_sound_arbiter: RTL and testbench

- Shares the single PIEZO output among all in-car sound requesters: horn, ESS alarm, start/stop chime, reverse beeper, turn-signal click and engine drone.
- Grants exactly one source at a time by fixed priority and sequences that source's on/off pattern on a 1 ms tick.
- Generates the square-wave tone for the granted source.
- Sits between the vehicle/warning logic and the PIEZO pin, replacing ad-hoc OR-ing of sound enables.

---
 rtl/piezo_sound_arbiter_if.sv | 33 +++
 rtl/piezo_sound_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_piezo_sound_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/piezo_sound_arbiter_if.sv
// ============================================================================
// piezo_sound_arbiter_if: sound request inputs and PIEZO/grant outputs.
// Rev 1.0
// ============================================================================
`default_nettype none

interface piezo_sound_arbiter_if;
  logic        tick_ms;
  logic        req_horn;
  logic        req_ess;
  logic        chime_start;
  logic        req_reverse;
  logic        turn_lamp;
  logic        engine_on;
  logic [13:0] rpm;
  logic        piezo_out;
  logic [2:0]  active_src;
  logic        busy;

  modport master (
    output tick_ms, req_horn, req_ess, chime_start, req_reverse,
           turn_lamp, engine_on, rpm,
    input  piezo_out, active_src, busy
  );

  modport slave (
    input  tick_ms, req_horn, req_ess, chime_start, req_reverse,
           turn_lamp, engine_on, rpm,
    output piezo_out, active_src, busy
  );
endinterface

`default_nettype wire

// File: rtl/piezo_sound_arbiter.sv
// ============================================================================
// piezo_sound_arbiter: fixed-priority sound source arbiter with pattern and tone generation.
// Rev 1.0
// ============================================================================
`default_nettype none

module piezo_sound_arbiter #(
  parameter int HORN_HALF     = 56818,
  parameter int ESS_HALF      = 25000,
  parameter int REV_HALF      = 31250,
  parameter int CLICK_HALF    = 12500,
  parameter int CHIME_HALF0   = 47778,
  parameter int CHIME_HALF1   = 37922,
  parameter int CHIME_HALF2   = 31888,
  parameter int ENG_BASE_HALF = 200000,
  parameter int ENG_MIN_HALF  = 60000
) (
  input  logic                  CLK,
  input  logic                  global_safe_rst,
  piezo_sound_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    SRC_IDLE  = 3'd0,
    SRC_DRONE = 3'd1,
    SRC_CLICK = 3'd2,
    SRC_REV   = 3'd3,
    SRC_CHIME = 3'd4,
    SRC_ESS   = 3'd5,
    SRC_HORN  = 3'd6
  } src_t;

  localparam logic [9:0]  ESS_ON_MS     = 10'd100;
  localparam logic [9:0]  ESS_PERIOD_MS = 10'd200;
  localparam logic [9:0]  REV_ON_MS     = 10'd300;
  localparam logic [9:0]  REV_PERIOD_MS = 10'd600;
  localparam logic [9:0]  CLICK_MS      = 10'd20;
  localparam logic [9:0]  NOTE_MS       = 10'd150;
  localparam logic [1:0]  LAST_NOTE     = 2'd2;
  localparam logic [17:0] ENG_BASE      = 18'(ENG_BASE_HALF);
  localparam logic [17:0] ENG_MIN       = 18'(ENG_MIN_HALF);
  localparam logic [17:0] ENG_SPAN      = ENG_BASE - ENG_MIN;

  src_t        active_q;
  src_t        next_src;
  logic        busy_q;
  logic        turn_prev;
  logic        chime_pend;
  logic        click_pend;
  logic [9:0]  ms_cnt;
  logic [9:0]  ms_nxt;
  logic [1:0]  note;
  logic [1:0]  note_nxt;
  logic [17:0] tone_cnt;
  logic        tone;
  logic [17:0] eng_half;
  logic [17:0] eng_calc;
  logic [17:0] rpm_x16;
  logic [17:0] half_sel;
  logic        pattern_on;
  logic        click_rise;
  logic        chime_done;
  logic        click_done;
  logic        chime_eff;
  logic        click_eff;
  logic        chime_block;
  logic        click_block;
  logic        restart;
  logic        wrap;

  assign click_rise = bus.turn_lamp & ~turn_prev;
  assign chime_done = (active_q == SRC_CHIME) && bus.tick_ms &&
                      (ms_cnt == NOTE_MS - 10'd1) && (note == LAST_NOTE);
  assign click_done = (active_q == SRC_CLICK) && bus.tick_ms &&
                      (ms_cnt == CLICK_MS - 10'd1);

  // A finishing latch drops out of arbitration in its last cycle unless re-armed.
  assign chime_eff = chime_pend & ~(chime_done & ~bus.chime_start);
  assign click_eff = click_pend & ~(click_done & ~click_rise);

  // Any higher-priority request cancels a one-shot pattern outright.
  assign chime_block = bus.req_horn | bus.req_ess;
  assign click_block = bus.req_horn | bus.req_ess | chime_eff | bus.req_reverse;

  always_comb begin
    next_src = SRC_IDLE;
    if (bus.req_horn)         next_src = SRC_HORN;
    else if (bus.req_ess)     next_src = SRC_ESS;
    else if (chime_eff)       next_src = SRC_CHIME;
    else if (bus.req_reverse) next_src = SRC_REV;
    else if (click_eff)       next_src = SRC_CLICK;
    else if (bus.engine_on)   next_src = SRC_DRONE;
  end

  assign restart = (next_src != active_q) ||
                   (bus.chime_start && (active_q == SRC_CHIME) && (next_src == SRC_CHIME));

  assign rpm_x16  = {bus.rpm, 4'b0000};
  assign eng_calc = (rpm_x16 > ENG_SPAN) ? ENG_MIN : (ENG_BASE - rpm_x16);

  always_comb begin
    pattern_on = 1'b0;
    half_sel   = 18'(HORN_HALF);
    case (active_q)
      SRC_HORN: begin
        pattern_on = 1'b1;
        half_sel   = 18'(HORN_HALF);
      end
      SRC_ESS: begin
        pattern_on = (ms_cnt < ESS_ON_MS);
        half_sel   = 18'(ESS_HALF);
      end
      SRC_CHIME: begin
        pattern_on = 1'b1;
        case (note)
          2'd0:    half_sel = 18'(CHIME_HALF0);
          2'd1:    half_sel = 18'(CHIME_HALF1);
          default: half_sel = 18'(CHIME_HALF2);
        endcase
      end
      SRC_REV: begin
        pattern_on = (ms_cnt < REV_ON_MS);
        half_sel   = 18'(REV_HALF);
      end
      SRC_CLICK: begin
        pattern_on = 1'b1;
        half_sel   = 18'(CLICK_HALF);
      end
      SRC_DRONE: begin
        pattern_on = 1'b1;
        half_sel   = eng_half;
      end
      default: begin
        pattern_on = 1'b0;
        half_sel   = 18'(HORN_HALF);
      end
    endcase
  end

  assign wrap = (tone_cnt >= half_sel - 18'd1);

  always_comb begin
    ms_nxt   = ms_cnt;
    note_nxt = note;
    if (bus.tick_ms) begin
      case (active_q)
        SRC_ESS:   ms_nxt = (ms_cnt == ESS_PERIOD_MS - 10'd1) ? 10'd0 : ms_cnt + 10'd1;
        SRC_REV:   ms_nxt = (ms_cnt == REV_PERIOD_MS - 10'd1) ? 10'd0 : ms_cnt + 10'd1;
        SRC_CLICK: begin
          if (ms_cnt != CLICK_MS - 10'd1) ms_nxt = ms_cnt + 10'd1;
        end
        SRC_CHIME: begin
          if (ms_cnt == NOTE_MS - 10'd1) begin
            ms_nxt = 10'd0;
            if (note != LAST_NOTE) note_nxt = note + 2'd1;
          end else begin
            ms_nxt = ms_cnt + 10'd1;
          end
        end
        default: ms_nxt = ms_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      active_q   <= SRC_IDLE;
      busy_q     <= 1'b0;
      turn_prev  <= 1'b0;
      chime_pend <= 1'b0;
      click_pend <= 1'b0;
      ms_cnt     <= 10'd0;
      note       <= 2'd0;
      tone_cnt   <= 18'd0;
      tone       <= 1'b0;
      eng_half   <= 18'd0;
    end else begin
      turn_prev <= bus.turn_lamp;

      if (bus.chime_start)              chime_pend <= 1'b1;
      else if (chime_done | chime_block) chime_pend <= 1'b0;

      if (click_rise)                   click_pend <= 1'b1;
      else if (click_done | click_block) click_pend <= 1'b0;

      active_q <= next_src;
      busy_q   <= (next_src != SRC_IDLE);

      // A new grant starts from a clean ON phase; any tick this cycle is dropped.
      if (restart) begin
        ms_cnt   <= 10'd0;
        note     <= 2'd0;
        tone_cnt <= 18'd0;
        tone     <= 1'b0;
        eng_half <= eng_calc;
      end else begin
        ms_cnt <= ms_nxt;
        note   <= note_nxt;
        if (!pattern_on) begin
          tone_cnt <= 18'd0;
          tone     <= 1'b0;
        end else if (wrap) begin
          tone_cnt <= 18'd0;
          tone     <= ~tone;
          // rpm only takes effect at a wrap so a drone half-period is never cut short.
          if (active_q == SRC_DRONE) eng_half <= eng_calc;
        end else begin
          tone_cnt <= tone_cnt + 18'd1;
        end
      end
    end
  end

  assign bus.piezo_out  = tone & pattern_on;
  assign bus.active_src = active_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_piezo_sound_arbiter.sv
// ============================================================================
// tb_piezo_sound_arbiter: directed checks of arbitration, patterns and tones with scaled half-periods.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_piezo_sound_arbiter;

  logic CLK;
  logic global_safe_rst;
  int   checks;
  int   errors;
  int   cyc;

  piezo_sound_arbiter_if bus();

  piezo_sound_arbiter #(
    .HORN_HALF     (5),
    .ESS_HALF      (4),
    .REV_HALF      (3),
    .CLICK_HALF    (2),
    .CHIME_HALF0   (7),
    .CHIME_HALF1   (6),
    .CHIME_HALF2   (5),
    .ENG_BASE_HALF (200),
    .ENG_MIN_HALF  (60)
  ) dut (
    .CLK             (CLK),
    .global_safe_rst (global_safe_rst),
    .bus             (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // 1 ms is scaled to 10 clock cycles.
  initial begin
    cyc         = 0;
    bus.tick_ms = 1'b0;
    forever begin
      @(posedge CLK);
      #0.5;
      cyc++;
      bus.tick_ms = ((cyc % 10) == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step(1);
  endtask

  // Length of the next complete high pulse on piezo_out; 0 if none within the bound.
  task automatic measure_high(output int n);
    int guard;
    n     = 0;
    guard = 0;
    while (bus.piezo_out !== 1'b0 && guard < 2000) begin step(1); guard++; end
    while (bus.piezo_out !== 1'b1 && guard < 2000) begin step(1); guard++; end
    while (bus.piezo_out === 1'b1 && guard < 2000) begin step(1); guard++; n++; end
    if (guard >= 2000) n = 0;
  endtask

  task automatic any_high(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      step(1);
      if (bus.piezo_out === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int   w;
    int   t0;
    int   dur;
    logic seen;

    checks = 0;
    errors = 0;
    global_safe_rst = 1'b1;
    bus.req_horn    = 1'b0;
    bus.req_ess     = 1'b0;
    bus.chime_start = 1'b0;
    bus.req_reverse = 1'b0;
    bus.turn_lamp   = 1'b0;
    bus.engine_on   = 1'b0;
    bus.rpm         = 14'd0;

    step(3);
    check("rst_piezo", 32'(bus.piezo_out), 0);
    check("rst_src", 32'(bus.active_src), 0);
    check("rst_busy", 32'(bus.busy), 0);
    global_safe_rst = 1'b0;
    step(2);

    // Engine drone
    bus.engine_on = 1'b1;
    step(1);
    check("drone_src", 32'(bus.active_src), 1);
    check("drone_busy", 32'(bus.busy), 1);
    measure_high(w);
    check("drone_rpm0_half", w, 200);
    bus.rpm = 14'd8000;
    step(500);
    measure_high(w);
    check("drone_clamp_half", w, 60);
    bus.rpm = 14'd5;
    step(300);
    measure_high(w);
    check("drone_rpm5_half", w, 120);
    bus.engine_on = 1'b0;
    step(2);
    check("drone_off_idle", 32'(bus.active_src), 0);

    // Chime sequence
    bus.chime_start = 1'b1;
    step(1);
    bus.chime_start = 1'b0;
    step(1);
    check("chime_src", 32'(bus.active_src), 4);
    t0 = cyc;
    measure_high(w);
    check("chime_note0", w, 7);
    wait_until(t0 + 1600);
    measure_high(w);
    check("chime_note1", w, 6);
    wait_until(t0 + 3100);
    measure_high(w);
    check("chime_note2", w, 5);
    while (bus.active_src == 3'd4 && (cyc - t0) < 6000) step(1);
    dur = cyc - t0;
    check("chime_len_ok", 32'((dur >= 4480) && (dur <= 4520)), 1);
    check("chime_end_idle", 32'(bus.active_src), 0);

    // Reverse preempted by horn
    bus.req_reverse = 1'b1;
    step(1);
    check("rev_src", 32'(bus.active_src), 3);
    measure_high(w);
    check("rev_half", w, 3);
    step(1500);
    bus.req_horn = 1'b1;
    step(1);
    check("horn_preempt_src", 32'(bus.active_src), 6);
    check("horn_change_piezo", 32'(bus.piezo_out), 0);
    measure_high(w);
    check("horn_half", w, 5);
    step(100);
    bus.req_horn = 1'b0;
    step(1);
    check("rev_resume_src", 32'(bus.active_src), 3);
    t0 = cyc;
    wait_until(t0 + 2850);
    measure_high(w);
    check("rev_restart_on", w, 3);
    wait_until(t0 + 3100);
    any_high(20, seen);
    check("rev_off_phase", 32'(seen), 0);
    bus.req_reverse = 1'b0;
    step(2);

    // Chime cancelled by ESS
    bus.chime_start = 1'b1;
    step(1);
    bus.chime_start = 1'b0;
    step(2000);
    bus.req_ess = 1'b1;
    step(1);
    check("ess_preempt_src", 32'(bus.active_src), 5);
    t0 = cyc;
    measure_high(w);
    check("ess_half", w, 4);
    wait_until(t0 + 1400);
    any_high(20, seen);
    check("ess_off_phase", 32'(seen), 0);
    wait_until(t0 + 2100);
    measure_high(w);
    check("ess_on_again", w, 4);
    bus.req_ess = 1'b0;
    step(2);
    check("ess_drop_no_chime", 32'(bus.active_src), 0);

    // Turn click over drone
    bus.engine_on = 1'b1;
    bus.rpm       = 14'd0;
    step(3);
    bus.turn_lamp = 1'b1;
    step(2);
    check("click_src", 32'(bus.active_src), 2);
    t0 = cyc;
    measure_high(w);
    check("click_half", w, 2);
    wait_until(t0 + 250);
    check("click_back_drone", 32'(bus.active_src), 1);
    bus.turn_lamp = 1'b0;
    step(100);
    bus.turn_lamp = 1'b1;
    step(2);
    check("click2_src", 32'(bus.active_src), 2);
    step(300);
    bus.turn_lamp = 1'b0;
    step(5);
    bus.req_horn = 1'b1;
    step(5);
    bus.turn_lamp = 1'b1;
    step(20);
    bus.req_horn = 1'b0;
    step(1);
    check("horn_rel_drone", 32'(bus.active_src), 1);
    seen = 1'b0;
    repeat (300) begin
      step(1);
      if (bus.active_src == 3'd2) seen = 1'b1;
    end
    check("no_click_after_horn", 32'(seen), 0);
    bus.engine_on = 1'b0;
    bus.turn_lamp = 1'b0;
    step(3);

    // Async reset mid-chime
    bus.chime_start = 1'b1;
    step(1);
    bus.chime_start = 1'b0;
    step(1);
    check("rst_chime_src", 32'(bus.active_src), 4);
    step(500);
    #2;
    global_safe_rst = 1'b1;
    #1;
    check("arst_piezo", 32'(bus.piezo_out), 0);
    check("arst_src", 32'(bus.active_src), 0);
    check("arst_busy", 32'(bus.busy), 0);
    step(1);
    global_safe_rst = 1'b0;
    step(100);
    check("arst_no_resume", 32'(bus.active_src), 0);
    any_high(20, seen);
    check("arst_silent", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
